// File: rtl/pulse_train_gen.sv
// Programmable pulse train generator: one-shot, burst of N, or continuous pulses.
// Optional PULSE_TRAIN_CNT_EN adds a saturating o_pulse_count output.
module pulse_train_gen #(
    parameter int WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_high_len,
    input  logic [WIDTH-1:0] i_burst_cnt,
    output logic             o_signal,
    output logic             o_busy,
`ifdef PULSE_TRAIN_CNT_EN
    output logic [WIDTH-1:0] o_pulse_count,
`endif
    output logic             o_done
);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_h;
    logic [WIDTH-1:0] r_l;
    logic [WIDTH-1:0] r_left;
    logic             r_cont;
    logic             r_signal;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_h;
    logic [WIDTH-1:0] w_l;
    logic [WIDTH-1:0] w_n;
    logic             w_cont;

    // Effective phase lengths and pulse count from the live config inputs
    assign w_h    = (i_high_len == '0) ? WIDTH'(1) : i_high_len;
    assign w_l    = (i_period > w_h) ? (i_period - w_h) : WIDTH'(1);
    assign w_n    = (i_mode == 2'd1 && i_burst_cnt != '0) ? i_burst_cnt : WIDTH'(1);
    assign w_cont = (i_mode == 2'd2);

`ifdef PULSE_TRAIN_CNT_EN
    logic [WIDTH-1:0] r_pulse_count;
    assign o_pulse_count = r_pulse_count;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_h      <= '0;
            r_l      <= '0;
            r_left   <= '0;
            r_cont   <= 1'b0;
            r_signal <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef PULSE_TRAIN_CNT_EN
            r_pulse_count <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state != StIdle && i_stop) begin
                r_state  <= StIdle;
                r_signal <= 1'b0;
                r_busy   <= 1'b0;
                r_cnt    <= '0;
                r_left   <= '0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (i_start && !i_stop) begin
                            r_state  <= StHigh;
                            r_signal <= 1'b1;
                            r_busy   <= 1'b1;
                            r_h      <= w_h;
                            r_l      <= w_l;
                            r_left   <= w_n;
                            r_cont   <= w_cont;
                            r_cnt    <= w_h - WIDTH'(1);
`ifdef PULSE_TRAIN_CNT_EN
                            r_pulse_count <= WIDTH'(1);
`endif
                        end
                    end
                    StHigh: begin
                        if (r_cnt == '0) begin
                            r_state  <= StLow;
                            r_signal <= 1'b0;
                            r_cnt    <= r_l - WIDTH'(1);
                        end else begin
                            r_cnt <= r_cnt - WIDTH'(1);
                        end
                    end
                    StLow: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - WIDTH'(1);
                        end else if (r_cont || r_left > WIDTH'(1)) begin
                            r_state  <= StHigh;
                            r_signal <= 1'b1;
                            r_cnt    <= r_h - WIDTH'(1);
                            if (!r_cont) begin
                                r_left <= r_left - WIDTH'(1);
                            end
`ifdef PULSE_TRAIN_CNT_EN
                            if (r_pulse_count != '1) begin
                                r_pulse_count <= r_pulse_count + WIDTH'(1);
                            end
`endif
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_left  <= '0;
                        end
                    end
                    default: begin
                        r_state  <= StIdle;
                        r_signal <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_signal = r_signal;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed self-checking bench for pulse_train_gen; define PULSE_TRAIN_CNT_EN to
// also check the pulse counter.
module tb_pulse_train_gen;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [WIDTH-1:0] period = '0;
    logic [WIDTH-1:0] high_len = '0;
    logic [WIDTH-1:0] burst_cnt = '0;
    logic             sig;
    logic             busy;
    logic             done;
`ifdef PULSE_TRAIN_CNT_EN
    logic [WIDTH-1:0] pcount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pulse_train_gen #(.WIDTH(WIDTH)) u_dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_mode      (mode),
        .i_period    (period),
        .i_high_len  (high_len),
        .i_burst_cnt (burst_cnt),
        .o_signal    (sig),
        .o_busy      (busy),
`ifdef PULSE_TRAIN_CNT_EN
        .o_pulse_count (pcount),
`endif
        .o_done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1 ns later; start is treated as a one-cycle pulse
    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Checks edges k_first..k_last after the accepting edge E0 (k=0 needs no tick).
    // n == 0 means continuous.
    task automatic seq_check(input string tag, input int h, input int l, input int n,
                             input int k_first, input int k_last);
        int p;
        logic es, eb, ed;
        p = h + l;
        for (int k = k_first; k <= k_last; k++) begin
            if (k > 0) tick();
            if (n == 0 || k < n * p) begin
                es = ((k % p) < h);
                eb = 1'b1;
                ed = 1'b0;
            end else begin
                es = 1'b0;
                eb = 1'b0;
                ed = (k == n * p);
            end
            check_eq($sformatf("%s k=%0d signal", tag, k), 32'(sig), 32'(es));
            check_eq($sformatf("%s k=%0d busy", tag, k), 32'(busy), 32'(eb));
            check_eq($sformatf("%s k=%0d done", tag, k), 32'(done), 32'(ed));
        end
    endtask

    task automatic cfg(input logic [1:0] m, input int per, input int hl, input int bc);
        mode      = m;
        period    = WIDTH'(per);
        high_len  = WIDTH'(hl);
        burst_cnt = WIDTH'(bc);
    endtask

    initial begin
        rst = 1'b1;
        #12;
        check_eq("reset signal", 32'(sig), 32'd0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
`ifdef PULSE_TRAIN_CNT_EN
        check_eq("reset pulse_count", 32'(pcount), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // One-shot: H=2, L=4
        cfg(2'd0, 6, 2, 0);
        start = 1'b1;
        tick();
        seq_check("oneshot", 2, 4, 1, 0, 8);
`ifdef PULSE_TRAIN_CNT_EN
        check_eq("oneshot pulse_count", 32'(pcount), 32'd1);
`endif

        // Burst of 3: H=1, L=3
        cfg(2'd1, 4, 1, 3);
        start = 1'b1;
        tick();
        seq_check("burst3", 1, 3, 3, 0, 14);
`ifdef PULSE_TRAIN_CNT_EN
        check_eq("burst3 pulse_count", 32'(pcount), 32'd3);
`endif

        // Continuous, high_len >= period: H=5, L=1; stop sampled at edge 21
        cfg(2'd2, 5, 5, 0);
        start = 1'b1;
        tick();
        seq_check("cont", 5, 1, 0, 0, 20);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("cont stop signal", 32'(sig), 32'd0);
        check_eq("cont stop busy", 32'(busy), 32'd0);
        check_eq("cont stop done", 32'(done), 32'd0);
        tick();
        check_eq("cont after stop done", 32'(done), 32'd0);
        check_eq("cont after stop busy", 32'(busy), 32'd0);
`ifdef PULSE_TRAIN_CNT_EN
        check_eq("cont pulse_count hold", 32'(pcount), 32'd4);
`endif

        // Degenerate config: high_len=0, burst_cnt=0, period=0 -> H=1, L=1, N=1
        cfg(2'd1, 0, 0, 0);
        start = 1'b1;
        tick();
        seq_check("zeros", 1, 1, 1, 0, 4);

        // Reserved mode acts as one-shot: H=1, L=2
        cfg(2'd3, 3, 1, 5);
        start = 1'b1;
        tick();
        seq_check("mode3", 1, 2, 1, 0, 5);

        // start and stop together in IDLE: stop wins
        cfg(2'd0, 4, 2, 0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("start+stop signal", 32'(sig), 32'd0);
        check_eq("start+stop busy", 32'(busy), 32'd0);
        tick();
        check_eq("start+stop idle busy", 32'(busy), 32'd0);

        // start pulsed mid-burst with new config: no effect. H=2, L=2, N=2
        cfg(2'd1, 4, 2, 2);
        start = 1'b1;
        tick();
        seq_check("midstart", 2, 2, 2, 0, 2);
        cfg(2'd2, 9, 5, 7);
        start = 1'b1;
        seq_check("midstart", 2, 2, 2, 3, 10);

        // start during the done cycle is accepted: H=1, L=1
        cfg(2'd0, 2, 1, 0);
        start = 1'b1;
        tick();
        seq_check("done+start a", 1, 1, 1, 0, 2);
        start = 1'b1;
        tick();
        seq_check("done+start b", 1, 1, 1, 0, 3);

        // Async reset between edges while high
        cfg(2'd0, 10, 8, 0);
        start = 1'b1;
        tick();
        tick();
        check_eq("pre-reset signal", 32'(sig), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async reset signal", 32'(sig), 32'd0);
        check_eq("async reset busy", 32'(busy), 32'd0);
        check_eq("async reset done", 32'(done), 32'd0);
        #3;
        rst = 1'b0;
        tick();
        cfg(2'd1, 3, 2, 2);
        start = 1'b1;
        tick();
        seq_check("post-reset", 2, 1, 2, 0, 7);
`ifdef PULSE_TRAIN_CNT_EN
        check_eq("post-reset pulse_count", 32'(pcount), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Synchronous, parametrised successor of the single fixed-width pulse generator.
- Produces programmable pulses on a single output. Each pulse has a programmable high length and period, measured in clock cycles.
- Supports three modes: one-shot, burst of N pulses, and continuous until stopped.
- Used as the stimulus and timing source for the clock/pulse exercises, driven from a bench or a controller FSM.

Parameters:
- WIDTH, 8, bit width of the period, high_len and burst_cnt fields and of the internal counters.

Ports:
- clock  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a pulse sequence; sampled only in IDLE
- stop  input  1  abort the active sequence
- mode  input  2  0 one-shot, 1 burst, 2 continuous, 3 reserved (behaves as one-shot)
- period  input  WIDTH  cycles per pulse, high plus low
- high_len  input  WIDTH  cycles signal stays high
- burst_cnt  input  WIDTH  number of pulses in burst mode
- signal  output  1  registered pulse output
- busy  output  1  high while a sequence is active
- done  output  1  one-cycle strobe on natural completion

Behaviour:
- Reset (asynchronous): state=IDLE, signal=0, busy=0, done=0, all counters 0. Applies at any time, including mid-pulse.
- States:
  - IDLE -> HIGH on start=1 and stop=0.
  - HIGH -> LOW when the high counter expires.
  - LOW -> HIGH if more pulses remain.
  - LOW -> IDLE when the sequence is complete.
- Config latch: mode, period, high_len and burst_cnt are latched at the edge that accepts start. Later input changes have no effect until the next start.
- Effective lengths:
  - H = max(high_len, 1).
  - L = period − H if period > H, else 1. The effective period is therefore H+L, never less than 2.
- Pulse count N:
  - one-shot: N = 1.
  - burst: N = max(burst_cnt, 1).
  - continuous: unbounded.
- Timing:
  - Start accepted at edge E0: signal=1 and busy=1 from E0.
  - signal falls at E0+H.
  - The next pulse rises at E0+H+L.
  - After the N-th pulse's low phase, at edge E0+N·(H+L): busy=0, done=1 for exactly one cycle, state=IDLE.
- Latency: start to signal rise is one edge, with no extra pipeline stage.
- start while busy: ignored, with no restart and no config re-latch.
- stop while busy: at the next edge state=IDLE, signal=0, busy=0, done stays 0. Counters are cleared.
- start and stop both high in IDLE: stop wins; remain in IDLE.
- done and start in the same cycle: the new start is accepted, because state is IDLE in that cycle.
- Continuous mode: never asserts done; only stop or reset ends it.
- Counters: all WIDTH bits. The burst counter counts down from N and never wraps, because N ≥ 1.

Optional Feature:
- Macro: PULSE_TRAIN_CNT_EN.
- When defined, adds output pulse_count [WIDTH-1:0]:
  - reset value 0; cleared when start is accepted;
  - increments at each rising edge of signal, starting at 1 on the first pulse;
  - saturates at all-ones (continuous mode);
  - holds its value after done or stop until the next start.
- When undefined: port absent, no counter logic, all other behaviour identical.

Test Plan:
- One-shot, period=6, high_len=2, start at edge 0 -> signal high edges 0–2, low edges 2–6; done=1 in cycle 6 only; busy=0 from 6.
- Burst, period=4, high_len=1, burst_cnt=3 -> rising edges of signal at 0, 4, 8; done at edge 12; PULSE_TRAIN_CNT_EN build: pulse_count=3.
- Continuous, period=5, high_len=5, i.e. high_len ≥ period -> H=5, L=1, period 6; stop at edge 20 -> signal=0, busy=0 at edge 21, done never asserted.
- Edge values, high_len=0, burst_cnt=0, burst mode -> a single 1-cycle pulse; period=0 yields H=1, L=1.
- start and stop both high in IDLE -> stays IDLE, signal=0. start pulsed mid-burst -> no effect on timing.
- Async reset asserted mid-HIGH, between edges -> signal, busy and done go to 0 immediately. After release, a new start runs a normal sequence.
